// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory size encodings (also used by
// the data memory), FSM state encoding and the alignment helper.
package lsu_pkg;

    localparam logic [1:0] MEM_SZ_NONE = 2'b00;
    localparam logic [1:0] MEM_SZ_BYTE = 2'b01;
    localparam logic [1:0] MEM_SZ_HALF = 2'b10;
    localparam logic [1:0] MEM_SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_e;

    // Natural alignment: halves on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == MEM_SZ_HALF && addr_lo[0] != 1'b0) mis = 1'b1;
        if (size == MEM_SZ_WORD && addr_lo != 2'b00)   mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension: picks the low byte/half/word of the raw memory word and
// sign- or zero-extends it to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic byte_sign;
    logic half_sign;

    assign byte_sign = raw_i[7]  & ~unsigned_i;
    assign half_sign = raw_i[15] & ~unsigned_i;

    always_comb begin
        data_o = '0;
        case (size_i)
            MEM_SZ_BYTE: data_o = {{24{byte_sign}}, raw_i[7:0]};
            MEM_SZ_HALF: data_o = {{16{half_sign}}, raw_i[15:0]};
            MEM_SZ_WORD: data_o = raw_i;
            default:     data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: one request at a time, one-cycle memory access,
// held response. Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [1:0]        mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fault_q;

    logic              accept;
    logic              req_fault;
    logic [31:0]       ext_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = (req_size == MEM_SZ_NONE) || is_misaligned(req_size, req_addr[1:0]);
`else
    assign req_fault = (req_size == MEM_SZ_NONE);
`endif

    load_extend u_load_extend (
        .raw_i      (mem_read_data),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    assign accept = (state_q == LSU_IDLE) && req_valid;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_write = MEM_SZ_NONE;
        mem_read  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_fault ? LSU_RESP : LSU_ACCESS;
            end
            LSU_ACCESS: begin
                if (we_q) mem_write = size_q;
                else      mem_read  = 1'b1;
                state_d = LSU_RESP;
            end
            LSU_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            size_q  <= MEM_SZ_NONE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                // Stores and faults respond with zero data, so clear it up front.
                rdata_q <= '0;
                fault_q <= req_fault;
            end else if (state_q == LSU_ACCESS && !we_q) begin
                rdata_q <= ext_data;
            end
        end
    end

    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_fault      = fault_q;

endmodule
